// File: rtl/kitchen_timer_pkg.sv
// Purpose: shared state encoding and digit limits for the kitchen timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kitchen_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } timer_state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // Number of 1 Hz ticks the alarm rings before falling back to IDLE.
  localparam int ALARM_TICKS_DEFAULT = 60;

endpackage

// File: rtl/bcd_mmss_counter.sv
// Purpose: four-digit BCD MM:SS register with increment, decrement and clear.
// Latency: 1 cycle from command to updated digits; flags are decoded from the registers.
// Backpressure: none, a command is applied on the edge it is presented.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load_zero         force 00:00 (wins over everything else)
//   inc_min, inc_sec  wrap-around increments of MM (00..99) and SS (00..59)
//   dec               count down one second with borrow chain (ignored at 00:00)
//   bin0..bin3        SS ones, SS tens, MM ones, MM tens
//   is_zero, is_one   value is 00:00 / 00:01
module bcd_mmss_counter
  import kitchen_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_zero,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       dec,
  output logic [3:0] bin0,
  output logic [3:0] bin1,
  output logic [3:0] bin2,
  output logic [3:0] bin3,
  output logic       is_zero,
  output logic       is_one
);

  assign is_zero = (bin3 == 4'd0) && (bin2 == 4'd0) && (bin1 == 4'd0) && (bin0 == 4'd0);
  assign is_one  = (bin3 == 4'd0) && (bin2 == 4'd0) && (bin1 == 4'd0) && (bin0 == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin0 <= 4'd0;
      bin1 <= 4'd0;
      bin2 <= 4'd0;
      bin3 <= 4'd0;
    end else if (load_zero) begin
      bin0 <= 4'd0;
      bin1 <= 4'd0;
      bin2 <= 4'd0;
      bin3 <= 4'd0;
    end else if (inc_min || inc_sec) begin
      // Seconds wrap 59->00 without touching the minutes.
      if (inc_sec) begin
        if (bin0 == DIGIT_MAX) begin
          bin0 <= 4'd0;
          bin1 <= (bin1 == SEC_TENS_MAX) ? 4'd0 : bin1 + 4'd1;
        end else begin
          bin0 <= bin0 + 4'd1;
        end
      end
      if (inc_min) begin
        if (bin2 == DIGIT_MAX) begin
          bin2 <= 4'd0;
          bin3 <= (bin3 == DIGIT_MAX) ? 4'd0 : bin3 + 4'd1;
        end else begin
          bin2 <= bin2 + 4'd1;
        end
      end
    end else if (dec && !is_zero) begin
      // Borrow ripples upward only while the lower digit is already zero.
      if (bin0 != 4'd0) begin
        bin0 <= bin0 - 4'd1;
      end else begin
        bin0 <= DIGIT_MAX;
        if (bin1 != 4'd0) begin
          bin1 <= bin1 - 4'd1;
        end else begin
          bin1 <= SEC_TENS_MAX;
          if (bin2 != 4'd0) begin
            bin2 <= bin2 - 4'd1;
          end else begin
            bin2 <= DIGIT_MAX;
            bin3 <= bin3 - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// Purpose: kitchen countdown timer FSM (IDLE/RUN/PAUSE/ALARM) around a BCD MM:SS counter.
// Latency: 1 cycle from button/tick pulse to registered digits, running and alarm.
// Backpressure: none; one-cycle pulses are always consumed, lower-priority ones in the same cycle are dropped.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   tick_1hz                        one-cycle pulse per second
//   btn_start/btn_clear/btn_min/btn_sec  debounced one-cycle button pulses
//   bin0..bin3                      BCD SS ones, SS tens, MM ones, MM tens
//   running, alarm                  registered state indicators
module kitchen_timer_ctrl
  import kitchen_timer_pkg::*;
#(
  parameter int ALARM_TICKS = ALARM_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_min,
  input  logic       btn_sec,
  output logic [3:0] bin0,
  output logic [3:0] bin1,
  output logic [3:0] bin2,
  output logic [3:0] bin3,
  output logic       running,
  output logic       alarm
);

  localparam int CW = $clog2(ALARM_TICKS + 1);
  localparam logic [CW-1:0] ACNT_LAST = CW'(ALARM_TICKS - 1);
  localparam logic [CW-1:0] ACNT_ONE  = CW'(1);

  timer_state_e  state_q, state_d;
  logic [CW-1:0] acnt_q, acnt_d;
  logic          load_zero, inc_min, inc_sec, dec;
  logic          is_zero, is_one;

  bcd_mmss_counter u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_zero (load_zero),
    .inc_min   (inc_min),
    .inc_sec   (inc_sec),
    .dec       (dec),
    .bin0      (bin0),
    .bin1      (bin1),
    .bin2      (bin2),
    .bin3      (bin3),
    .is_zero   (is_zero),
    .is_one    (is_one)
  );

  always_comb begin
    state_d   = state_q;
    acnt_d    = '0;          // counter only survives while staying in ALARM
    load_zero = 1'b0;
    inc_min   = 1'b0;
    inc_sec   = 1'b0;
    dec       = 1'b0;

    if (btn_clear) begin
      state_d   = IDLE;
      load_zero = 1'b1;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          // A start press wins the cycle even when it is refused at 00:00.
          if (btn_start) begin
            if (!is_zero) state_d = RUN;
          end else begin
            inc_min = btn_min;
            inc_sec = btn_sec;
          end
        end
        RUN: begin
          if (btn_start) begin
            state_d = PAUSE;
          end else if (tick_1hz) begin
            dec = 1'b1;
            // Reaching 00:00 and entering ALARM happen on the same edge.
            if (is_one || is_zero) state_d = ALARM;
          end
        end
        ALARM: begin
          acnt_d = acnt_q;
          if (btn_start) begin
            state_d = IDLE;
            acnt_d  = '0;
          end else if (tick_1hz) begin
            if (acnt_q == ACNT_LAST) begin
              state_d = IDLE;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + ACNT_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // running/alarm come from state_d so they are true flops aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acnt_q  <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
      running <= (state_d == RUN);
      alarm   <= (state_d == ALARM);
    end
  end

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
module tb_kitchen_timer_ctrl;

  localparam int AT = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_sec = 1'b0;
  logic [3:0] bin0, bin1, bin2, bin3;
  logic       running, alarm;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model: minutes, seconds, mode, and alarm ticks seen so far.
  int m_mm, m_ss, m_mode, m_ticks;

  kitchen_timer_ctrl #(.ALARM_TICKS(AT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .btn_min   (btn_min),
    .btn_sec   (btn_sec),
    .bin0      (bin0),
    .bin1      (bin1),
    .bin2      (bin2),
    .bin3      (bin3),
    .running   (running),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_dig;
    logic        legal;
    exp_dig = {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
    legal   = (bin0 <= 4'd9) && (bin1 <= 4'd5) && (bin2 <= 4'd9) && (bin3 <= 4'd9);
    chk({tag, "/digits"}, {16'd0, bin3, bin2, bin1, bin0}, {16'd0, exp_dig});
    chk({tag, "/running"}, {31'd0, running}, (m_mode == M_RUN) ? 32'd1 : 32'd0);
    chk({tag, "/alarm"}, {31'd0, alarm}, (m_mode == M_ALARM) ? 32'd1 : 32'd0);
    chk({tag, "/bcd_legal"}, {31'd0, legal}, 32'd1);
  endtask

  task automatic model_reset();
    m_mm = 0; m_ss = 0; m_mode = M_IDLE; m_ticks = 0;
  endtask

  // Behaviour expressed in seconds arithmetic, with priority clear > start > set > tick.
  task automatic model_step(input bit clr, input bit st, input bit mi, input bit se, input bit tk);
    int total;
    if (clr) begin
      model_reset();
    end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
      if (st) begin
        if (m_mm != 0 || m_ss != 0) m_mode = M_RUN;
      end else begin
        if (mi) m_mm = (m_mm + 1) % 100;
        if (se) m_ss = (m_ss + 1) % 60;
      end
    end else if (m_mode == M_RUN) begin
      if (st) begin
        m_mode = M_PAUSE;
      end else if (tk) begin
        total = m_mm * 60 + m_ss - 1;
        m_mm  = total / 60;
        m_ss  = total % 60;
        if (total == 0) begin
          m_mode  = M_ALARM;
          m_ticks = 0;
        end
      end
    end else begin
      if (st) begin
        m_mode = M_IDLE;
      end else if (tk) begin
        m_ticks++;
        if (m_ticks == AT) m_mode = M_IDLE;
      end
    end
  endtask

  task automatic cyc(input string tag, input bit clr, input bit st, input bit mi,
                     input bit se, input bit tk);
    @(negedge clk);
    btn_clear = clr; btn_start = st; btn_min = mi; btn_sec = se; tick_1hz = tk;
    model_step(clr, st, mi, se, tk);
    @(posedge clk);
    #1;
    btn_clear = 1'b0; btn_start = 1'b0; btn_min = 1'b0; btn_sec = 1'b0; tick_1hz = 1'b0;
    check_all(tag);
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) cyc("min", 0, 0, 1, 0, 0);
  endtask

  task automatic press_sec(input int n);
    for (int i = 0; i < n; i++) cyc("sec", 0, 0, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Start refused at 00:00; wraps of SS and MM
    cyc("start_at_zero", 0, 1, 0, 0, 0);
    cyc("tick_idle", 0, 0, 0, 0, 1);
    press_sec(60);
    check_all("sec_wrap");
    press_min(100);
    check_all("min_wrap");

    // 01:00 -> 00:59
    press_min(1);
    cyc("run_0100", 0, 1, 0, 0, 0);
    cyc("min_ignored_run", 0, 0, 1, 1, 0);
    cyc("tick_0059", 0, 0, 0, 0, 1);
    cyc("clear_run", 1, 0, 0, 0, 0);

    // 10:00 -> 09:59 full borrow chain
    press_min(10);
    cyc("run_1000", 0, 1, 0, 0, 0);
    cyc("tick_0959", 0, 0, 0, 0, 1);
    cyc("clear2", 1, 0, 1, 0, 1);

    // 00:02 -> alarm -> auto-clear after AT ticks
    press_sec(2);
    cyc("run_0002", 0, 1, 0, 0, 0);
    cyc("tick_0001", 0, 0, 0, 0, 1);
    cyc("tick_alarm", 0, 0, 0, 0, 1);
    for (int i = 0; i < AT; i++) begin
      cyc("alarm_idle", 0, 0, 1, 1, 0);
      cyc("alarm_tick", 0, 0, 0, 0, 1);
    end

    // Pause priority over tick, then resume
    press_sec(30);
    cyc("run_0030", 0, 1, 0, 0, 0);
    cyc("pause_vs_tick", 0, 1, 0, 0, 1);
    cyc("tick_paused", 0, 0, 0, 0, 1);
    cyc("sec_in_pause", 0, 0, 0, 1, 0);
    cyc("resume", 0, 1, 0, 0, 0);
    cyc("tick_resumed", 0, 0, 0, 0, 1);
    cyc("clear3", 1, 0, 0, 0, 0);

    // Both increments together
    cyc("min_and_sec", 0, 0, 1, 1, 0);

    // Alarm dismissed by start; next alarm counts from zero again
    cyc("run_0101", 0, 1, 0, 0, 0);
    cyc("clear_to_zero", 1, 0, 0, 0, 0);
    press_sec(1);
    cyc("run_0001", 0, 1, 0, 0, 0);
    cyc("alarm_from_one", 0, 0, 0, 0, 1);
    cyc("alarm_tick1", 0, 0, 0, 0, 1);
    cyc("alarm_start", 0, 1, 0, 0, 0);
    press_sec(1);
    cyc("run_again", 0, 1, 0, 0, 0);
    cyc("alarm_again", 0, 0, 0, 0, 1);
    for (int i = 0; i < AT; i++) cyc("alarm_count", 0, 0, 0, 0, 1);
    press_sec(1);
    cyc("run_clr", 0, 1, 0, 0, 0);
    cyc("alarm_clr", 0, 0, 0, 0, 1);
    cyc("alarm_clear_btn", 1, 0, 0, 0, 0);

    // Asynchronous reset mid-RUN at 05:17
    press_min(5);
    press_sec(17);
    cyc("run_0517", 0, 1, 0, 0, 0);
    cyc("tick_0516", 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst_tick", 0, 0, 0, 0, 1);
    cyc("post_rst_start", 0, 1, 0, 0, 0);

    // Randomised events against the model
    for (int i = 0; i < 4000; i++) begin
      cyc("rand",
          $urandom_range(63) == 0,
          $urandom_range(15) == 0,
          $urandom_range(31) == 0,
          $urandom_range(5) == 0,
          $urandom_range(2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/kitchen_timer_ctrl.md
KITCHEN_TIMER_CTRL -- requirements
Module: kitchen_timer_ctrl

Interface
REQ-001 Parameter: ALARM_TICKS, 60, number of tick_1hz pulses the alarm stays active before auto-clearing to IDLE.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick_1hz  input  1  one-clk-wide pulse, once per second, synchronous to clk.
REQ-005 btn_start  input  1  one-clk pulse (debounced upstream); start/pause toggle.
REQ-006 btn_clear  input  1  one-clk pulse; clear to 00:00, return to IDLE.
REQ-007 btn_min  input  1  one-clk pulse; increment minutes.
REQ-008 btn_sec  input  1  one-clk pulse; increment seconds.
REQ-009 bin0  output  4  BCD seconds ones (0-9).
REQ-010 bin1  output  4  BCD seconds tens (0-5).
REQ-011 bin2  output  4  BCD minutes ones (0-9).
REQ-012 bin3  output  4  BCD minutes tens (0-9).
REQ-013 running  output  1  high in RUN.
REQ-014 alarm  output  1  high in ALARM.

Function
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE, ALARM; all outputs registered, no combinational input-to-output paths.
REQ-016 IDLE/PAUSE: btn_min SHALL increment MM 00..99 in BCD, wrapping 99->00; SS unchanged.
REQ-017 IDLE/PAUSE: btn_sec SHALL increment SS 00..59 in BCD, wrapping 59->00 with no carry into MM.
REQ-018 btn_min/btn_sec in RUN or ALARM SHALL be ignored.
REQ-019 IDLE/PAUSE + btn_start: -> RUN next edge if value != 00:00; else ignored, stay put.
REQ-020 RUN + btn_start: -> PAUSE, value held.
REQ-021 RUN + tick_1hz: value SHALL decrement by one second, same edge; borrows: bin0 0->9 borrows bin1; bin1 0->5 borrows bin2; bin2 0->9 borrows bin3.
REQ-022 RUN, tick_1hz with value 00:01: value -> 00:00 and state -> ALARM on the same edge; alarm high from the next cycle.
REQ-023 ALARM: value held at 00:00; internal tick counter counts tick_1hz; after ALARM_TICKS ticks -> IDLE.
REQ-024 ALARM + btn_start or btn_clear: -> IDLE next edge, alarm low, counter cleared.
REQ-025 btn_clear in any state SHALL force value 00:00 and state IDLE; highest priority.
REQ-026 Simultaneous priority: btn_clear > btn_start > btn_min/btn_sec > tick_1hz; lower events in the same cycle SHALL be discarded (e.g. RUN, btn_start+tick: PAUSE, no decrement).
REQ-027 btn_min and btn_sec together: both increments applied.
REQ-028 Digits SHALL never hold non-BCD or out-of-range values (bin1 <= 5).

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, bin0..bin3 = 0, running = 0, alarm = 0, alarm tick counter = 0.
REQ-030 Reset mid-RUN or mid-ALARM SHALL abandon the count; no decrement on the release edge; first action only on a subsequent event.

Structure
REQ-031 Shared package kitchen_timer_pkg SHALL hold state encoding (IDLE, RUN, PAUSE, ALARM), constants SEC_TENS_MAX = 5, DIGIT_MAX = 9, and ALARM_TICKS default.
REQ-032 One sub-module, bcd_mmss_counter, SHALL hold the four BCD digits with load-zero, inc_min, inc_sec, dec and is_zero/is_one flags; FSM lives in kitchen_timer_ctrl.
REQ-033 Alarm tick counter width SHALL be $clog2(ALARM_TICKS+1).

Verification
REQ-034 Set 01:00 via btn_min, btn_start, 1 tick -> 00:59, running=1.
REQ-035 Set 10:00, run, 1 tick -> 09:59 (full borrow chain across all four digits).
REQ-036 Set 00:02, run, 2 ticks -> 00:00, alarm=1, running=0; ALARM_TICKS further ticks -> IDLE, alarm=0.
REQ-037 RUN at 00:30, btn_start and tick_1hz same cycle -> PAUSE, display stays 00:30; btn_start -> RUN resumes.
REQ-038 IDLE 00:00 btn_start -> stays IDLE; btn_sec x60 -> 00:00 (wrap, MM unchanged); btn_min x100 -> 00:00.
REQ-039 RUN at 05:17, rst_n low mid-cycle -> outputs 0 immediately (asynchronous), state IDLE after release.
